// File: rtl/coin_scheduler_if.sv
// Control/tick inputs and slot/score outputs of the coin scheduler.
// The master side drives game control and ticks; the slave side is the scheduler.
interface coin_scheduler_if #(
  parameter int unsigned RND_W = 20
);
  logic             start;
  logic             pause;
  logic             game_over;
  logic             spawn_tick;
  logic             fall_tick;
  logic [RND_W-1:0] rnd;
  logic [1:0]       player_lane;
  logic [5:0]       coin_lane;
  logic [29:0]      coin_x;
  logic [26:0]      coin_y;
  logic             collect;
  logic [7:0]       coin_count;
  logic [1:0]       state;

  modport master (
    output start, pause, game_over, spawn_tick, fall_tick, rnd, player_lane,
    input  coin_lane, coin_x, coin_y, collect, coin_count, state
  );

  modport slave (
    input  start, pause, game_over, spawn_tick, fall_tick, rnd, player_lane,
    output coin_lane, coin_x, coin_y, collect, coin_count, state
  );
endinterface

// File: rtl/coin_scheduler.sv
// Three-slot coin scheduler: spawn, fall, retire and pickup of lane coins,
// driven by spawn/fall tick enables, plus the saturating collected-coin counter.
module coin_scheduler #(
  parameter int unsigned RND_W     = 20,
  parameter int unsigned LANE_SPAN = 100000,
  parameter int unsigned LANE1_X   = 175,
  parameter int unsigned LANE2_X   = 295,
  parameter int unsigned LANE3_X   = 415,
  parameter int unsigned Y_BOTTOM  = 480,
  parameter int unsigned PLAYER_Y  = 400,
  parameter int unsigned HIT_WIN   = 16,
  parameter int unsigned MIN_GAP   = 40
) (
  input logic             clk,
  input logic             rst,
  coin_scheduler_if.slave bus
);
  localparam int unsigned NSLOT  = 3;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FREEZE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q [NSLOT];
  logic [LANE_W-1:0] lane_d [NSLOT];
  logic [X_W-1:0]    x_q    [NSLOT];
  logic [X_W-1:0]    x_d    [NSLOT];
  logic [Y_W-1:0]    y_q    [NSLOT];
  logic [Y_W-1:0]    y_d    [NSLOT];
  logic              collect_q, collect_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [RND_W-1:0]  rnd_s;
  logic [LANE_W-1:0] spawn_lane;
  logic [Y_W-1:0]    y_inc  [NSLOT];
  logic [NSLOT-1:0]  active, retire, pickup, crowd;
  logic [1:0]        pickup_cnt;
  logic              free_ok;
  logic [1:0]        free_idx;
  logic              spawn_ok;
  logic [CNT_W:0]    count_sum;

  assign rnd_s = bus.rnd;

  function automatic logic [X_W-1:0] lane_x(input logic [LANE_W-1:0] l);
    case (l)
      2'd1:    return X_W'(LANE1_X);
      2'd2:    return X_W'(LANE2_X);
      2'd3:    return X_W'(LANE3_X);
      default: return '0;
    endcase
  endfunction

  // Lane decode of the random sample; out-of-range values spawn nothing.
  always_comb begin
    if (32'(rnd_s) < LANE_SPAN)          spawn_lane = 2'd1;
    else if (32'(rnd_s) < 2 * LANE_SPAN) spawn_lane = 2'd2;
    else if (32'(rnd_s) < 3 * LANE_SPAN) spawn_lane = 2'd3;
    else                                 spawn_lane = 2'd0;
  end

  // Per-slot fall outcome and spawn eligibility, all from pre-edge slot contents.
  always_comb begin
    pickup_cnt = '0;
    free_ok    = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      y_inc[i]  = y_q[i] + Y_W'(1);
      active[i] = (lane_q[i] != '0);
      retire[i] = active[i] && (32'(y_inc[i]) > Y_BOTTOM);
      pickup[i] = active[i] && !retire[i] && (bus.player_lane != '0) &&
                  (lane_q[i] == bus.player_lane) &&
                  (32'(y_inc[i]) >= PLAYER_Y) && (32'(y_inc[i]) < PLAYER_Y + HIT_WIN);
      crowd[i]  = active[i] && (lane_q[i] == spawn_lane) && (32'(y_q[i]) < MIN_GAP);
      pickup_cnt = pickup_cnt + 2'(pickup[i]);
    end
    // Descending scan so the lowest free index wins.
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_ok  = 1'b1;
        free_idx = 2'(i);
      end
    end
    spawn_ok  = bus.spawn_tick && (spawn_lane != '0) && free_ok && (crowd == '0);
    count_sum = {1'b0, count_q} + (CNT_W + 1)'(pickup_cnt);
  end

  // Next-state and slot/counter update.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    x_d       = x_q;
    y_d       = y_q;
    collect_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (bus.game_over) begin
          state_d = IDLE;
          for (int i = 0; i < NSLOT; i++) begin
            lane_d[i] = '0;
            x_d[i]    = '0;
            y_d[i]    = '0;
          end
        end else if (bus.pause) begin
          state_d = FREEZE;
        end else begin
          if (bus.fall_tick) begin
            for (int i = 0; i < NSLOT; i++) begin
              if (retire[i] || pickup[i]) begin
                lane_d[i] = '0;
                x_d[i]    = '0;
                y_d[i]    = '0;
              end else if (active[i]) begin
                y_d[i] = y_inc[i];
              end
            end
            collect_d = (pickup_cnt != '0);
            count_d   = count_sum[CNT_W] ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
          end
          // Target slot was free before the edge, so the fall above never touched it.
          for (int i = 0; i < NSLOT; i++) begin
            if (spawn_ok && (free_idx == 2'(i))) begin
              lane_d[i] = spawn_lane;
              x_d[i]    = lane_x(spawn_lane);
              y_d[i]    = '0;
            end
          end
        end
      end
      FREEZE: begin
        if (bus.game_over) begin
          state_d = IDLE;
          for (int i = 0; i < NSLOT; i++) begin
            lane_d[i] = '0;
            x_d[i]    = '0;
            y_d[i]    = '0;
          end
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      collect_q <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        lane_q[i] <= '0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      collect_q <= collect_d;
      count_q   <= count_d;
      for (int i = 0; i < NSLOT; i++) begin
        lane_q[i] <= lane_d[i];
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
      end
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_pack
    assign bus.coin_lane[LANE_W*g +: LANE_W] = lane_q[g];
    assign bus.coin_x[X_W*g +: X_W]          = x_q[g];
    assign bus.coin_y[Y_W*g +: Y_W]          = y_q[g];
  end

  assign bus.collect    = collect_q;
  assign bus.coin_count = count_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_coin_scheduler.sv
// Bench for coin_scheduler: vector table, directed corner sequences and
// randomized traffic, all checked against a slot-level reference model.
module tb_coin_scheduler;
  localparam int unsigned RND_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;

  coin_scheduler_if #(.RND_W(RND_W)) bus();

  coin_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers per slot.
  int m_state;
  int m_cnt;
  bit m_collect;
  int m_lane [3];
  int m_y    [3];

  typedef struct {
    bit         st, pa, go, sp, fa;
    int         r;
    int         pl;
    int         e_state;
    logic [5:0] e_lane;
    int         e_y0;
    bit         e_col;
    int         e_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_x(input int l);
    return (l == 0) ? 0 : 175 + 120 * (l - 1);
  endfunction

  function automatic int decode_lane(input int r);
    return (r / 100000 < 3) ? r / 100000 + 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt = 0;
    m_collect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_lane[i] = 0;
      m_y[i] = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_lane[i] = 0;
      m_y[i] = 0;
    end
  endtask

  task automatic model_step(input bit st, pa, go, sp, fa, input int r, input int pl);
    int nl [3];
    int ny [3];
    int hits;
    int ln;
    int tgt;
    bit crowded;
    m_collect = 1'b0;
    case (m_state)
      0: if (st) begin m_state = 1; m_cnt = 0; end
      1: begin
        if (go) begin m_state = 0; model_clear(); end
        else if (pa) m_state = 2;
        else begin
          nl = m_lane;
          ny = m_y;
          hits = 0;
          if (fa) begin
            for (int i = 0; i < 3; i++) begin
              if (m_lane[i] != 0) begin
                if (m_y[i] + 1 > 480) begin nl[i] = 0; ny[i] = 0; end
                else if (pl != 0 && m_lane[i] == pl && m_y[i] + 1 >= 400 && m_y[i] + 1 < 416) begin
                  nl[i] = 0; ny[i] = 0; hits++;
                end else ny[i] = m_y[i] + 1;
              end
            end
          end
          if (sp) begin
            ln = decode_lane(r);
            tgt = -1;
            crowded = 1'b0;
            for (int i = 0; i < 3; i++) begin
              if (m_lane[i] == 0 && tgt < 0) tgt = i;
              if (m_lane[i] == ln && m_y[i] < 40) crowded = 1'b1;
            end
            if (ln != 0 && tgt >= 0 && !crowded) begin nl[tgt] = ln; ny[tgt] = 0; end
          end
          m_lane = nl;
          m_y = ny;
          m_cnt = (m_cnt + hits > 255) ? 255 : m_cnt + hits;
          m_collect = (hits > 0);
        end
      end
      default: begin
        if (go) begin m_state = 0; model_clear(); end
        else if (!pa) m_state = 1;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [5:0]  el;
    logic [29:0] ex;
    logic [26:0] ey;
    for (int i = 0; i < 3; i++) begin
      el[2*i +: 2]  = 2'(m_lane[i]);
      ex[10*i +: 10] = 10'(lane_x(m_lane[i]));
      ey[9*i +: 9]  = 9'(m_y[i]);
    end
    chk({tag, ".state"},      32'(bus.state),      32'(m_state));
    chk({tag, ".coin_lane"},  32'(bus.coin_lane),  32'(el));
    chk({tag, ".coin_x"},     32'(bus.coin_x),     32'(ex));
    chk({tag, ".coin_y"},     32'(bus.coin_y),     32'(ey));
    chk({tag, ".collect"},    32'(bus.collect),    32'(m_collect));
    chk({tag, ".coin_count"}, 32'(bus.coin_count), 32'(m_cnt));
  endtask

  task automatic step(input bit st, pa, go, sp, fa, input int r, input int pl);
    bus.start       = st;
    bus.pause       = pa;
    bus.game_over   = go;
    bus.spawn_tick  = sp;
    bus.fall_tick   = fa;
    bus.rnd         = RND_W'(r);
    bus.player_lane = 2'(pl);
    @(posedge clk);
    #1;
    model_step(st, pa, go, sp, fa, r, pl);
    check_all("model");
  endtask

  task automatic do_fall(input int pl);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, pl);
  endtask

  task automatic do_spawn(input int r, input int pl);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r, pl);
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_over();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit pz;
    int pl;
    bus.start = 1'b0; bus.pause = 1'b0; bus.game_over = 1'b0;
    bus.spawn_tick = 1'b0; bus.fall_tick = 1'b0; bus.rnd = '0; bus.player_lane = '0;

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b1;

    //            st    pa    go    sp    fa    rnd     pl  state lane       y0 col cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,      0,  1, 6'b000000, 0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 150000, 0,  1, 6'b000010, 0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,      0,  1, 6'b000010, 1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0,      0,  2, 6'b000010, 1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0,      0,  2, 6'b000010, 1, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,      0,  1, 6'b000010, 1, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 150000, 0,  1, 6'b000010, 1, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 350000, 0,  1, 6'b000010, 1, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,      0,  1, 6'b000110, 1, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20000,  0,  0, 6'b000000, 0, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,      0,  0, 6'b000000, 0, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,      0,  1, 6'b000000, 0, 1'b0, 0};

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].st, tbl[k].pa, tbl[k].go, tbl[k].sp, tbl[k].fa, tbl[k].r, tbl[k].pl);
      chk($sformatf("vec%0d.state", k), 32'(bus.state),      32'(tbl[k].e_state));
      chk($sformatf("vec%0d.lane", k),  32'(bus.coin_lane),  32'(tbl[k].e_lane));
      chk($sformatf("vec%0d.y0", k),    32'(bus.coin_y[8:0]), 32'(tbl[k].e_y0));
      chk($sformatf("vec%0d.col", k),   32'(bus.collect),    32'(tbl[k].e_col));
      chk($sformatf("vec%0d.cnt", k),   32'(bus.coin_count), 32'(tbl[k].e_cnt));
    end

    // Bottom retire: lane-2 coin never picked up by a lane-1 player.
    do_spawn(150000, 1);
    chk("retire.lane0", 32'(bus.coin_lane[1:0]), 32'd2);
    chk("retire.x0",    32'(bus.coin_x[9:0]),    32'd295);
    for (int k = 1; k <= 481; k++) begin
      do_fall(1);
      if (k <= 480) chk("retire.y0", 32'(bus.coin_y[8:0]), 32'(k));
      else begin
        chk("retire.freed_lane", 32'(bus.coin_lane[1:0]), 32'd0);
        chk("retire.freed_y",    32'(bus.coin_y[8:0]),    32'd0);
      end
      chk("retire.collect", 32'(bus.collect), 32'd0);
    end

    // Pickup at the top of the window.
    do_spawn(50000, 1);
    for (int k = 1; k <= 400; k++) begin
      do_fall(1);
      if (k < 400) chk("pickup.collect_early", 32'(bus.collect), 32'd0);
    end
    chk("pickup.lane0",   32'(bus.coin_lane[1:0]), 32'd0);
    chk("pickup.collect", 32'(bus.collect),        32'd1);
    chk("pickup.count",   32'(bus.coin_count),     32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    chk("pickup.collect_pulse", 32'(bus.collect), 32'd0);

    // Asynchronous reset mid-game, between clock edges.
    do_spawn(250000, 0);
    repeat (3) do_fall(0);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.lane",  32'(bus.coin_lane),  32'd0);
    chk("async_rst.count", 32'(bus.coin_count), 32'd0);
    #1 rst = 1'b1;

    // All slots full: fourth spawn dropped.
    do_start();
    do_spawn(0, 0);      repeat (45) do_fall(0);
    do_spawn(100000, 0); repeat (45) do_fall(0);
    do_spawn(200000, 0); repeat (45) do_fall(0);
    do_spawn(0, 0);
    chk("full.lane", 32'(bus.coin_lane), 32'(6'b111001));
    chk("full.y",    32'(bus.coin_y),    32'({9'd45, 9'd90, 9'd135}));

    // Spacing suppression in the same lane.
    do_over();
    do_start();
    do_spawn(0, 0);
    repeat (10) do_fall(0);
    do_spawn(0, 0);
    chk("gap.lane", 32'(bus.coin_lane),   32'(6'b000001));
    chk("gap.y0",   32'(bus.coin_y[8:0]), 32'd10);

    // Same-cycle spawn and fall, then pause with a fall tick.
    do_over();
    do_start();
    do_spawn(0, 0);
    repeat (5) do_fall(0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 100000, 0);
    chk("both.lane", 32'(bus.coin_lane),    32'(6'b001001));
    chk("both.y0",   32'(bus.coin_y[8:0]),  32'd6);
    chk("both.y1",   32'(bus.coin_y[17:9]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("freeze.state", 32'(bus.state),       32'd2);
    chk("freeze.y0",    32'(bus.coin_y[8:0]), 32'd6);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("freeze_over.state", 32'(bus.state),     32'd0);
    chk("freeze_over.lane",  32'(bus.coin_lane), 32'd0);

    // Seven pickups, then game_over keeps the count and start clears it.
    do_start();
    for (int n = 0; n < 7; n++) begin
      do_spawn(0, 1);
      repeat (400) do_fall(1);
    end
    chk("seven.count", 32'(bus.coin_count), 32'd7);
    do_spawn(200000, 1);
    repeat (3) do_fall(1);
    do_over();
    chk("over.state", 32'(bus.state),      32'd0);
    chk("over.lane",  32'(bus.coin_lane),  32'd0);
    chk("over.y",     32'(bus.coin_y),     32'd0);
    chk("over.count", 32'(bus.coin_count), 32'd7);
    do_start();
    chk("restart.count", 32'(bus.coin_count), 32'd0);

    // Randomized traffic against the model.
    pz = 1'b0;
    pl = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom % 60 == 0) pz = ~pz;
      if ($urandom % 100 == 0) pl = int'($urandom % 4);
      step(($urandom % 200) == 0, pz, ($urandom % 2500) == 0,
           ($urandom % 4) == 0, ($urandom % 3) != 0,
           int'($urandom_range(0, 399999)), pl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/coin_scheduler.md
Name: coin_scheduler

Overview:
- Owns the three coin slots of the coin lane datapath: spawn, fall, retire and pickup.
- Replaces the free-running spawn/fall pair with one single-clock scheduler driven by tick enables.
- Allocates free slots to newly spawned coins, advances active coins on the fall tick, and retires coins that pass the screen bottom.
- Detects pickups against the player lane and keeps the score-side coin counter. Its outputs feed the VGA coin renderer and the score display.

Parameters:
- RND_W, 20, width of rnd input.
- LANE_SPAN, 100000, rnd range per lane: [0,S) lane 1, [S,2S) lane 2, [2S,3S) lane 3, else no spawn.
- LANE1_X, 175, x pixel for lane 1.
- LANE2_X, 295, x pixel for lane 2.
- LANE3_X, 415, x pixel for lane 3.
- Y_BOTTOM, 480, a coin with y > Y_BOTTOM is retired.
- PLAYER_Y, 400, top of the pickup window.
- HIT_WIN, 16, height of the pickup window; a hit needs PLAYER_Y <= y < PLAYER_Y+HIT_WIN.
- MIN_GAP, 40, minimum y of the newest coin in the target lane before another spawn in that lane.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a game
- pause  in  1  level; hold all coins
- game_over  in  1  one-cycle pulse; end the game
- spawn_tick  in  1  one-cycle spawn enable
- fall_tick  in  1  one-cycle fall enable
- rnd  in  RND_W  random value, sampled on spawn_tick
- player_lane  in  2  player lane, 1..3 (0 = airborne, cannot collect)
- coin_lane  out  6  2 bits per slot: 0 = empty, 1..3 = lane
- coin_x  out  30  10 bits per slot
- coin_y  out  27  9 bits per slot
- collect  out  1  one-cycle pulse on any pickup
- coin_count  out  8  coins collected, saturates at 255
- state  out  2  0 IDLE, 1 RUN, 2 FREEZE

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE.
- All outputs are registered. Effects of inputs sampled at edge N are visible after edge N.
- State transitions:
  - IDLE: ticks ignored, slots held empty. start -> RUN, and coin_count cleared to 0 on the same edge.
  - RUN: game_over -> IDLE. Else pause=1 -> FREEZE.
  - FREEZE: ticks ignored, slots and count held. game_over -> IDLE. Else pause=0 -> RUN.
  - Entering IDLE clears all slots (lane, x, y = 0); coin_count is held.
  - game_over has priority over pause and ticks in the same cycle.
- Fall (RUN and fall_tick), for each slot that was active before the edge:
  - y_new = y+1 (9-bit).
  - If y_new > Y_BOTTOM: slot freed (lane, x, y = 0).
  - Else if lane == player_lane and player_lane != 0 and PLAYER_Y <= y_new < PLAYER_Y+HIT_WIN: slot freed, counted as a pickup.
  - Else y = y_new.
- Pickups:
  - collect = 1 for one cycle if any slot is picked up on this edge.
  - coin_count += number of pickups on this edge (0..3), saturating at 255.
- Spawn (RUN and spawn_tick):
  - Lane is decoded from rnd; no-lane range -> no spawn.
  - The target slot is the lowest-index slot that was free before the edge. No free slot -> spawn dropped silently.
  - Spacing: spawn is suppressed if any pre-edge active slot in the same lane has y < MIN_GAP.
  - A spawned slot gets lane, x = LANEn_X, y = 0.
- spawn_tick and fall_tick in the same cycle:
  - Fall applies only to pre-existing slots; the new coin starts at y=0, not 1.
  - A slot freed by this fall is not reusable until a later spawn_tick.
- pause asserted in the same cycle as a tick: the tick is ignored (transition to FREEZE wins).
- start while in RUN/FREEZE is ignored.

Test Plan:
- Reset then start; spawn_tick with rnd=150000 -> slot0 lane=2, x=295, y=0, state=1, coin_count=0.
- 481 fall_ticks after that spawn, player_lane=1 -> y increments to 480, then slot0 freed on tick 481; collect never asserted.
- Spawn rnd=50000, player_lane=1, 400 fall_ticks -> on tick 400 the slot is freed, collect pulses once, coin_count=1.
- Three spawns into lanes 1, 2, 3 (fall_ticks in between), then a fourth spawn -> dropped, and slots unchanged. A lane-1 spawn while the lane-1 coin has y=10 -> suppressed.
- spawn_tick and fall_tick in the same cycle with slot0 at y=5 -> slot0 y=6, slot1 y=0. pause=1 with fall_tick -> FREEZE, y unchanged.
- Mid-game rst low -> asynchronous clear of all outputs. game_over with count=7 -> IDLE, slots cleared, count=7. Next start -> count=0.
